// File: rtl/i2c_ctrl_pkg.sv
// Shared constants and FSM state encoding for the I2C control-register slave.
package i2c_ctrl_pkg;

  localparam logic [7:0] REG_RX_FREQ0 = 8'd0;
  localparam logic [7:0] REG_TX_FREQ0 = 8'd4;
  localparam logic [7:0] REG_S_RATE   = 8'd8;
  localparam logic [7:0] REG_TX_LEVEL = 8'd9;
  localparam logic [7:0] REG_ID       = 8'd10;
  localparam logic [7:0] REG_LAST     = 8'd10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with one-cycle history; flags SCL edges and START/STOP.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [0] first sync flop, [1] synchronized value, [2] previous synchronized value
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_ctrl_regs.sv
// I2C slave register block: shadow registers written byte-wise, committed on STOP.
module i2c_ctrl_regs
  import i2c_ctrl_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR   = 7'h6A,
  parameter logic [31:0] RX_FREQ_RST  = 32'h0000_0000,
  parameter logic [31:0] TX_FREQ_RST  = 32'h0000_0000,
  parameter logic [7:0]  S_RATE_RST   = 8'd0,
  parameter logic [7:0]  TX_LEVEL_RST = 8'd0,
  parameter logic [7:0]  DEVICE_ID    = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire         slave_SDA,
  input  logic        slave_SCL,
  output logic [31:0] rx_freq,
  output logic [31:0] tx_freq,
  output logic [7:0]  s_rate,
  output logic [7:0]  tx_level,
  output logic        busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk_i      (clock),
    .rst_i      (reset),
    .scl_i      (slave_SCL),
    .sda_i      (slave_SDA),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  i2c_state_e  state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        mack_q, mack_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic [31:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic [7:0]  sr_sh_q, sr_sh_d, lvl_sh_q, lvl_sh_d;
  logic [9:0]  dirty_q, dirty_d;
  logic [31:0] rx_freq_q, rx_freq_d, tx_freq_q, tx_freq_d;
  logic [7:0]  s_rate_q, s_rate_d, tx_level_q, tx_level_d;

  logic [7:0]  rd_ptr;
  logic [7:0]  rd_byte;

  // First read byte comes from the current pointer, later ones from the next.
  always_comb begin
    rd_ptr  = (state_q == ST_ADDR_ACK) ? ptr_q : ptr_q + 8'd1;
    rd_byte = '0;
    if (rd_ptr < REG_TX_FREQ0)
      rd_byte = rx_freq_q[{~rd_ptr[1:0], 3'b000} +: 8];
    else if (rd_ptr < REG_S_RATE)
      rd_byte = tx_freq_q[{~rd_ptr[1:0], 3'b000} +: 8];
    else if (rd_ptr == REG_S_RATE)
      rd_byte = s_rate_q;
    else if (rd_ptr == REG_TX_LEVEL)
      rd_byte = tx_level_q;
    else if (rd_ptr == REG_ID)
      rd_byte = DEVICE_ID;
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    mack_d     = mack_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    sr_sh_d    = sr_sh_q;
    lvl_sh_d   = lvl_sh_q;
    dirty_d    = dirty_q;
    rx_freq_d  = rx_freq_q;
    tx_freq_d  = tx_freq_q;
    s_rate_d   = s_rate_q;
    tx_level_d = tx_level_q;

    if (stop_det) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (dirty_q[i])     rx_freq_d[8*(3-i) +: 8] = rx_sh_q[8*(3-i) +: 8];
        if (dirty_q[i + 4]) tx_freq_d[8*(3-i) +: 8] = tx_sh_q[8*(3-i) +: 8];
      end
      if (dirty_q[8]) s_rate_d   = sr_sh_q;
      if (dirty_q[9]) tx_level_d = lvl_sh_q;
      dirty_d = '0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (scl_rise) begin
      unique case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          shift_d  = {shift_q[6:0], sda_s};
          bitcnt_d = bitcnt_q + 4'd1;
        end
        ST_RDATA:     bitcnt_d = bitcnt_q + 4'd1;
        ST_RDATA_ACK: mack_d   = ~sda_s;
        default: ;
      endcase
    end else if (scl_fall) begin
      // A byte is processed on the SCL fall that ends its 8th bit, so the
      // ACK drive lines up with the 9th clock.
      unique case (state_q)
        ST_ADDR: begin
          if (bitcnt_q == 4'd8) begin
            bitcnt_d = '0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              rw_d     = shift_q[0];
              sda_oe_d = 1'b1;
              state_d  = ST_ADDR_ACK;
            end else begin
              state_d  = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (rw_q) begin
            shift_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
            state_d  = ST_RDATA;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_PTR;
          end
        end
        ST_PTR: begin
          if (bitcnt_q == 4'd8) begin
            bitcnt_d = '0;
            ptr_d    = shift_q;
            sda_oe_d = 1'b1;
            state_d  = ST_PTR_ACK;
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          sda_oe_d = 1'b0;
          state_d  = ST_WDATA;
        end
        ST_WDATA: begin
          if (bitcnt_q == 4'd8) begin
            bitcnt_d = '0;
            if (ptr_q < REG_TX_FREQ0)
              rx_sh_d[{~ptr_q[1:0], 3'b000} +: 8] = shift_q;
            else if (ptr_q < REG_S_RATE)
              tx_sh_d[{~ptr_q[1:0], 3'b000} +: 8] = shift_q;
            else if (ptr_q == REG_S_RATE)
              sr_sh_d = shift_q;
            else if (ptr_q == REG_TX_LEVEL)
              lvl_sh_d = shift_q;
            if (ptr_q < REG_LAST)
              dirty_d = dirty_q | (10'd1 << ptr_q);
            ptr_d    = ptr_q + 8'd1;
            sda_oe_d = 1'b1;
            state_d  = ST_WDATA_ACK;
          end
        end
        ST_RDATA: begin
          if (bitcnt_q == 4'd8) begin
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
            state_d  = ST_RDATA_ACK;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        ST_RDATA_ACK: begin
          if (mack_q) begin
            ptr_d    = ptr_q + 8'd1;
            shift_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
            state_d  = ST_RDATA;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_sh_q    <= RX_FREQ_RST;
      tx_sh_q    <= TX_FREQ_RST;
      sr_sh_q    <= S_RATE_RST;
      lvl_sh_q   <= TX_LEVEL_RST;
      dirty_q    <= '0;
      rx_freq_q  <= RX_FREQ_RST;
      tx_freq_q  <= TX_FREQ_RST;
      s_rate_q   <= S_RATE_RST;
      tx_level_q <= TX_LEVEL_RST;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      sr_sh_q    <= sr_sh_d;
      lvl_sh_q   <= lvl_sh_d;
      dirty_q    <= dirty_d;
      rx_freq_q  <= rx_freq_d;
      tx_freq_q  <= tx_freq_d;
      s_rate_q   <= s_rate_d;
      tx_level_q <= tx_level_d;
    end
  end

  assign slave_SDA = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_freq   = rx_freq_q;
  assign tx_freq   = tx_freq_q;
  assign s_rate    = s_rate_q;
  assign tx_level  = tx_level_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_ctrl_regs.sv
// Directed bench for i2c_ctrl_regs: bit-banged I2C master with hand-computed expectations.
module tb_i2c_ctrl_regs;

  localparam int Q = 2000;  // quarter SCL bit period; four control clocks

  logic        clock;
  logic        reset;
  logic        scl;
  logic        m_low;
  wire         sda;
  logic [31:0] rx_freq, tx_freq;
  logic [7:0]  s_rate, tx_level;
  logic        busy;

  int checks = 0;
  int errors = 0;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_ctrl_regs #(
    .SLAVE_ADDR   (7'h6A),
    .RX_FREQ_RST  (32'h0000_0000),
    .TX_FREQ_RST  (32'h0000_0000),
    .S_RATE_RST   (8'd0),
    .TX_LEVEL_RST (8'd0),
    .DEVICE_ID    (8'hA5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .slave_SDA (sda),
    .slave_SCL (scl),
    .rx_freq   (rx_freq),
    .tx_freq   (tx_freq),
    .s_rate    (s_rate),
    .tx_level  (tx_level),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #250 clock = ~clock;

  task automatic i2c_start();
    m_low = 1'b0; #Q;
    scl   = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q;
    scl   = 1'b1; #Q;
    m_low = 1'b0; #(4*Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_low = ~b[i]; #Q;
      scl   = 1'b1;  #(2*Q);
      scl   = 1'b0;  #Q;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_low = 1'b0; #Q;
    scl   = 1'b1; #Q;
    ack   = sda;  #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic give_ack);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1;
      #Q; b[i] = sda;
      #Q; scl = 1'b0;
      #Q;
    end
    m_low = give_ack; #Q;
    scl   = 1'b1;     #(2*Q);
    scl   = 1'b0;     #Q;
    m_low = 1'b0;
  endtask

  task automatic test_reset();
    #100;
    checks++;
    if (rx_freq !== 32'h0 || tx_freq !== 32'h0 || s_rate !== 8'h0 || tx_level !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h %h %h %h expected all zero", rx_freq, tx_freq, s_rate, tx_level);
    end
    checks++;
    if (busy !== 1'b0 || sda !== 1'b1) begin
      errors++;
      $display("FAIL reset_bus got busy=%b sda=%b expected busy=0 sda=1", busy, sda);
    end
    #400 reset = 1'b0;
    #(4*Q);
  endtask

  task automatic test_burst_write();
    logic [7:0] bytes [6];
    logic ack;
    logic torn;
    bytes = '{8'hD4, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    i2c_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL burst_busy got %b expected 1", busy);
    end
    for (int k = 0; k < 6; k++) begin
      send_byte(bytes[k], ack);
      checks++;
      if (ack !== 1'b0) begin
        errors++;
        $display("FAIL burst_ack byte %0d got %b expected 0", k, ack);
      end
    end
    m_low = 1'b1; #Q;
    scl   = 1'b1; #Q;
    checks++;
    if (rx_freq !== 32'h0) begin
      errors++;
      $display("FAIL burst_before_stop got %h expected 00000000", rx_freq);
    end
    m_low = 1'b0;
    torn  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (rx_freq !== 32'h0 && rx_freq !== 32'h1234_5678) torn = 1'b1;
    end
    checks++;
    if (torn !== 1'b0 || rx_freq !== 32'h1234_5678) begin
      errors++;
      $display("FAIL burst_commit got %h torn=%b expected 12345678 torn=0", rx_freq, torn);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_busy_after_stop got %b expected 0", busy);
    end
    #(2*Q);
  endtask

  task automatic test_multi_reg();
    logic ack;
    i2c_start();
    send_byte(8'hD4, ack);
    send_byte(8'h08, ack);
    send_byte(8'h03, ack);
    send_byte(8'h80, ack);
    i2c_stop();
    checks++;
    if (s_rate !== 8'h03 || tx_level !== 8'h80) begin
      errors++;
      $display("FAIL multi_regs got s_rate=%h tx_level=%h expected 03 80", s_rate, tx_level);
    end
    checks++;
    if (tx_freq !== 32'h0 || rx_freq !== 32'h1234_5678) begin
      errors++;
      $display("FAIL multi_untouched got tx=%h rx=%h expected 00000000 12345678", tx_freq, rx_freq);
    end
  endtask

  task automatic test_readback();
    logic ack;
    logic [7:0] b0, b1;
    i2c_start();
    send_byte(8'hD4, ack);
    send_byte(8'h09, ack);
    i2c_start();
    send_byte(8'hD5, ack);
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL read_addr_ack got %b expected 0", ack);
    end
    recv_byte(b0, 1'b1);
    recv_byte(b1, 1'b0);
    checks++;
    if (b0 !== 8'h80) begin
      errors++;
      $display("FAIL read_tx_level got %h expected 80", b0);
    end
    checks++;
    if (b1 !== 8'hA5) begin
      errors++;
      $display("FAIL read_id got %h expected a5", b1);
    end
    #Q;
    checks++;
    if (sda !== 1'b1) begin
      errors++;
      $display("FAIL read_release got sda=%b expected 1", sda);
    end
    i2c_stop();
  endtask

  task automatic test_wrong_addr();
    logic ack;
    i2c_start();
    send_byte(8'hA0, ack);
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL wrong_addr_ack got %b expected 1", ack);
    end
    send_byte(8'h00, ack);
    send_byte(8'hFF, ack);
    i2c_stop();
    checks++;
    if (rx_freq !== 32'h1234_5678 || tx_freq !== 32'h0 || s_rate !== 8'h03 || tx_level !== 8'h80) begin
      errors++;
      $display("FAIL wrong_addr_regs got %h %h %h %h expected 12345678 00000000 03 80", rx_freq, tx_freq, s_rate, tx_level);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wrong_addr_busy got %b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    logic ack;
    i2c_start();
    send_byte(8'hD4, ack);
    send_byte(8'h04, ack);
    send_byte(8'hAA, ack);
    send_bits(8'h55, 4);
    i2c_stop();
    checks++;
    if (tx_freq !== 32'hAA00_0000) begin
      errors++;
      $display("FAIL abort_tx_freq got %h expected aa000000", tx_freq);
    end
    checks++;
    if (rx_freq !== 32'h1234_5678 || s_rate !== 8'h03 || tx_level !== 8'h80) begin
      errors++;
      $display("FAIL abort_others got %h %h %h expected 12345678 03 80", rx_freq, s_rate, tx_level);
    end
  endtask

  task automatic test_ptr_wrap();
    logic ack;
    i2c_start();
    send_byte(8'hD4, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack);
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL wrap_unmapped_ack got %b expected 0", ack);
    end
    send_byte(8'h22, ack);
    i2c_stop();
    checks++;
    if (rx_freq !== 32'h2234_5678) begin
      errors++;
      $display("FAIL wrap_rx_freq got %h expected 22345678", rx_freq);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clock);
    #100 reset = 1'b1;
    #1;
    checks++;
    if (rx_freq !== 32'h0 || tx_freq !== 32'h0 || s_rate !== 8'h0 || tx_level !== 8'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %h %h %h %h busy=%b expected all zero", rx_freq, tx_freq, s_rate, tx_level, busy);
    end
    #500 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    scl   = 1'b1;
    m_low = 1'b0;
    test_reset();
    test_burst_write();
    test_multi_reg();
    test_readback();
    test_wrong_addr();
    test_abort();
    test_ptr_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
